// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency ID lookup,
// MEM-stage resolution/update, and branch/mispredict performance counters.
module branch_predictor #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  pc_ID,
  input  logic             is_branch_ID,
  input  logic             stall,
  output logic             BP_ID,
  output logic [PC_W-1:0]  pc_BP,
  input  logic             br_valid_MEM,
  input  logic [PC_W-1:0]  pc_MEM,
  input  logic             pred_MEM,
  input  logic             actual_MEM,
  input  logic [PC_W-1:0]  target_MEM,
  output logic             taken_MEM,
  output logic [PC_W-1:0]  next_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;

  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0][TAG_W-1:0] tag;
  logic [DEPTH-1:0][PC_W-1:0]  target;
  logic [DEPTH-1:0][1:0]       ctr;

  logic [IDX_W-1:0] idx_id, idx_mem;
  logic [TAG_W-1:0] tag_id, tag_mem;
  logic             hit_id, hit_mem;
  logic [1:0]       ctr_mem, ctr_nxt;

  assign idx_id  = pc_ID[IDX_W-1:0];
  assign tag_id  = pc_ID[PC_W-1:IDX_W];
  assign idx_mem = pc_MEM[IDX_W-1:0];
  assign tag_mem = pc_MEM[PC_W-1:IDX_W];

  assign hit_id  = valid[idx_id]  && (tag[idx_id]  == tag_id);
  assign hit_mem = valid[idx_mem] && (tag[idx_mem] == tag_mem);
  assign ctr_mem = ctr[idx_mem];

  // A resolving mispredict owns the redirect this cycle, so it masks any ID prediction.
  assign taken_MEM = br_valid_MEM & (pred_MEM != actual_MEM) & ~rst;
  assign BP_ID     = is_branch_ID & hit_id & ctr[idx_id][1] & ~stall & ~taken_MEM & ~rst;
  assign pc_BP     = BP_ID ? target[idx_id] : '0;
  assign next_pc   = actual_MEM ? target_MEM : pc_MEM + PC_W'(1);

  always_comb begin
    ctr_nxt = ctr_mem;
    if (actual_MEM && ctr_mem != 2'b11)      ctr_nxt = ctr_mem + 2'b01;
    else if (!actual_MEM && ctr_mem != 2'b00) ctr_nxt = ctr_mem - 2'b01;
  end

  // Tag and target carry no reset: they are only read once valid is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      ctr        <= {DEPTH{2'b01}};
      br_count   <= '0;
      miss_count <= '0;
    end else if (br_valid_MEM) begin
      if (hit_mem) begin
        ctr[idx_mem] <= ctr_nxt;
        if (actual_MEM) target[idx_mem] <= target_MEM;
      end else if (actual_MEM) begin
        valid[idx_mem]  <= 1'b1;
        tag[idx_mem]    <= tag_mem;
        target[idx_mem] <= target_MEM;
        ctr[idx_mem]    <= 2'b10;
      end
      br_count   <= br_count + CNT_W'(1);
      miss_count <= miss_count + CNT_W'(taken_MEM);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; narrow counters so wrap is reachable.
module tb_branch_predictor;
  localparam int PC_W = 32, IDX_W = 4, CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [PC_W-1:0]  pc_ID, pc_BP, pc_MEM, target_MEM, next_pc;
  logic             is_branch_ID, stall, BP_ID;
  logic             br_valid_MEM, pred_MEM, actual_MEM, taken_MEM;
  logic [CNT_W-1:0] br_count, miss_count;

  int vectors = 0;
  int miscompares = 0;

  branch_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pc_ID(pc_ID), .is_branch_ID(is_branch_ID), .stall(stall),
    .BP_ID(BP_ID), .pc_BP(pc_BP), .br_valid_MEM(br_valid_MEM), .pc_MEM(pc_MEM),
    .pred_MEM(pred_MEM), .actual_MEM(actual_MEM), .target_MEM(target_MEM),
    .taken_MEM(taken_MEM), .next_pc(next_pc), .br_count(br_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic res(input logic [31:0] pc, input logic pred, input logic act, input logic [31:0] tgt);
    br_valid_MEM = 1'b1; pc_MEM = pc; pred_MEM = pred; actual_MEM = act; target_MEM = tgt;
  endtask

  task automatic mem_idle();
    br_valid_MEM = 1'b0; pc_MEM = '0; pred_MEM = 1'b0; actual_MEM = 1'b0; target_MEM = '0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; is_branch_ID = 1'b1; pc_ID = 32'h24;
    res(32'h24, 1'b0, 1'b1, 32'h10);
    @(negedge clk); #1;
    chk("rst_bp", BP_ID, 0);
    chk("rst_taken", taken_MEM, 0);
    @(negedge clk); #1;
    chk("rst_br", br_count, 0);
    chk("rst_miss", miss_count, 0);

    // Cold lookup misses
    rst = 1'b0; mem_idle(); #1;
    chk("cold_bp", BP_ID, 0);
    chk("cold_pcbp", pc_BP, 0);

    // First taken resolve allocates
    @(negedge clk); res(32'h24, 1'b0, 1'b1, 32'h10); #1;
    chk("alloc_taken", taken_MEM, 1);
    chk("alloc_npc", next_pc, 32'h10);
    @(negedge clk); mem_idle(); #1;
    chk("alloc_bp", BP_ID, 1);
    chk("alloc_pcbp", pc_BP, 32'h10);
    chk("alloc_br", br_count, 1);
    chk("alloc_miss", miss_count, 1);

    // Not-taken mispredict masks the ID hit in the same cycle
    @(negedge clk); res(32'h24, 1'b1, 1'b0, 32'h0); #1;
    chk("nt1_taken", taken_MEM, 1);
    chk("nt1_npc", next_pc, 32'h25);
    chk("prec_bp", BP_ID, 0);
    @(negedge clk); res(32'h24, 1'b0, 1'b0, 32'h0); #1;
    chk("nt2_bp", BP_ID, 0);
    chk("nt2_taken", taken_MEM, 0);
    chk("nt2_br", br_count, 2);
    chk("nt2_miss", miss_count, 2);

    // Train back up from 00: 00->01->10
    @(negedge clk); res(32'h24, 1'b0, 1'b1, 32'h10); #1;
    chk("c00_bp", BP_ID, 0);
    chk("c00_br", br_count, 3);
    @(negedge clk); res(32'h24, 1'b0, 1'b1, 32'h10); #1;
    chk("c01_bp", BP_ID, 0);
    chk("c01_miss", miss_count, 3);
    @(negedge clk); mem_idle(); #1;
    chk("c10_bp", BP_ID, 1);
    chk("c10_pcbp", pc_BP, 32'h10);

    // Aliasing on idx 4
    pc_ID = 32'h34; #1;
    chk("alias_bp", BP_ID, 0);
    chk("alias_pcbp", pc_BP, 0);
    res(32'h34, 1'b0, 1'b1, 32'h40); #1;
    chk("alias_taken", taken_MEM, 1);
    @(negedge clk); mem_idle(); #1;
    chk("repl_bp", BP_ID, 1);
    chk("repl_pcbp", pc_BP, 32'h40);
    chk("repl_br", br_count, 6);
    chk("repl_miss", miss_count, 5);
    pc_ID = 32'h24; #1;
    chk("evict_bp", BP_ID, 0);

    // Saturation: alloc 10 then 11,11,11,11
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); res(32'h24, 1'b1, 1'b1, 32'h50);
    end
    @(negedge clk); mem_idle(); #1;
    chk("sat_bp", BP_ID, 1);
    chk("sat_pcbp", pc_BP, 32'h50);
    chk("sat_br", br_count, 11);
    @(negedge clk); res(32'h24, 1'b1, 1'b0, 32'h0); #1;
    chk("sat_nt_taken", taken_MEM, 1);
    // Same-cycle update: lookup sees the pre-update counter
    @(negedge clk); res(32'h24, 1'b0, 1'b0, 32'h0); #1;
    chk("sat_hold_bp", BP_ID, 1);
    chk("sat_miss", miss_count, 6);
    @(negedge clk); res(32'h24, 1'b1, 1'b1, 32'h60); #1;
    chk("rw_old_bp", BP_ID, 0);
    chk("rw_old_pcbp", pc_BP, 0);
    @(negedge clk); mem_idle(); #1;
    chk("rw_new_bp", BP_ID, 1);
    chk("rw_new_pcbp", pc_BP, 32'h60);
    chk("rw_br", br_count, 14);

    // Stall masks a hit
    stall = 1'b1; #1;
    chk("stall_bp", BP_ID, 0);
    chk("stall_pcbp", pc_BP, 0);
    stall = 1'b0; #1;
    chk("unstall_bp", BP_ID, 1);

    // next_pc wrap and counter wrap
    @(negedge clk); res(32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0); #1;
    chk("npc_wrap", next_pc, 0);
    chk("npc_wrap_taken", taken_MEM, 0);
    @(negedge clk); res(32'h7, 1'b0, 1'b0, 32'h0); #1;
    chk("npc_seq", next_pc, 32'h8);
    chk("pre_wrap_br", br_count, 15);
    @(negedge clk); mem_idle(); #1;
    chk("wrap_br", br_count, 0);
    chk("wrap_miss", miss_count, 6);
    pc_ID = 32'hFFFF_FFFF; #1;
    chk("nt_nowrite_bp", BP_ID, 0);

    // Mid-run reset drops learned state
    @(negedge clk); rst = 1'b1; pc_ID = 32'h24; #1;
    chk("rst2_bp", BP_ID, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst2_after_bp", BP_ID, 0);
    chk("rst2_br", br_count, 0);
    chk("rst2_miss", miss_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
